// File: rtl/pp_uart_autobaud.sv
// Auto-baud controller: times a 0x55 sync character on rxd, derives the 14-bit
// fractional baud divisor, loads it and pulses the baud generator's soft reset.
module pp_uart_autobaud #(
    parameter logic [13:0] DEFAULT_DIV = 14'd434,
    parameter logic [13:0] MIN_DIV     = 14'd16,
    parameter logic [16:0] TIMEOUT_C   = 17'd131068
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        rxd,
    output logic [13:0] baud_div,
    output logic        soft_rst,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd1;
    localparam logic [2:0] ST_WAIT_EDGE = 3'd2;
    localparam logic [2:0] ST_MEASURE   = 3'd3;
    localparam logic [2:0] ST_CHECK     = 3'd4;
    localparam logic [2:0] ST_APPLY     = 3'd5;

    logic        rxd_meta_r;
    logic        rxd_sync_r;
    logic        rxd_hist_r;
    logic [2:0]  state_r;
    logic [3:0]  idle_cnt_r;
    logic [16:0] c_r;
    logic [16:0] ival_r;
    logic [16:0] ival_mem_r [0:3];
    logic [1:0]  edge_idx_r;
    logic [13:0] baud_div_r;
    logic        soft_rst_r;
    logic        busy_r;
    logic        done_r;
    logic        err_r;
    logic [1:0]  err_code_r;

    logic        fall_s;
    logic [16:0] c_rnd_s;
    logic [13:0] div_s;
    logic [16:0] ival_next_s;
    logic        mismatch_s;

    // True when interval ik deviates from the reference i0 by more than a quarter of i0.
    function automatic logic ival_off(input logic [16:0] ik, input logic [16:0] i0);
        logic [16:0] diff;
        if (ik > i0) begin
            diff = ik - i0;
        end else begin
            diff = i0 - ik;
        end
        return diff > {2'b00, i0[16:2]};
    endfunction

    // Edge detect, rounded divisor (C covers 8 bit times -> /8 gives sixteenths of a bit) and interval consistency.
    always_comb begin
        fall_s      = rxd_hist_r & ~rxd_sync_r;
        c_rnd_s     = c_r + 17'd4;
        div_s       = c_rnd_s[16:3];
        ival_next_s = ival_r + 17'd1;
        mismatch_s  = ival_off(ival_mem_r[1], ival_mem_r[0]) |
                      ival_off(ival_mem_r[2], ival_mem_r[0]) |
                      ival_off(ival_mem_r[3], ival_mem_r[0]);
    end

    // Two-flop synchroniser plus history flop; idle line level is 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_meta_r <= 1'b1;
            rxd_sync_r <= 1'b1;
            rxd_hist_r <= 1'b1;
        end else begin
            rxd_meta_r <= rxd;
            rxd_sync_r <= rxd_meta_r;
            rxd_hist_r <= rxd_sync_r;
        end
    end

    // Detection FSM, measurement counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            idle_cnt_r <= 4'd0;
            c_r        <= 17'd0;
            ival_r     <= 17'd0;
            edge_idx_r <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                ival_mem_r[i] <= 17'd0;
            end
            baud_div_r <= DEFAULT_DIV;
            soft_rst_r <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            err_code_r <= 2'd0;
        end else begin
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            soft_rst_r <= 1'b1;
            // A start during APPLY is dropped so the new divisor always lands.
            if (start && (state_r != ST_APPLY)) begin
                state_r    <= ST_WAIT_IDLE;
                busy_r     <= 1'b1;
                err_code_r <= 2'd0;
                idle_cnt_r <= 4'd0;
                c_r        <= 17'd0;
                ival_r     <= 17'd0;
                edge_idx_r <= 2'd0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_r <= ST_IDLE;
                    end
                    ST_WAIT_IDLE: begin
                        if (!rxd_sync_r) begin
                            idle_cnt_r <= 4'd0;
                        end else if (idle_cnt_r == 4'd15) begin
                            state_r <= ST_WAIT_EDGE;
                        end else begin
                            idle_cnt_r <= idle_cnt_r + 4'd1;
                        end
                    end
                    ST_WAIT_EDGE: begin
                        if (fall_s) begin
                            c_r        <= 17'd0;
                            ival_r     <= 17'd0;
                            edge_idx_r <= 2'd0;
                            state_r    <= ST_MEASURE;
                        end
                    end
                    ST_MEASURE: begin
                        // Timeout fires before C can reach the limit, keeping the divisor within 14 bits.
                        if (c_r == (TIMEOUT_C - 17'd1)) begin
                            err_r      <= 1'b1;
                            err_code_r <= 2'd2;
                            busy_r     <= 1'b0;
                            state_r    <= ST_IDLE;
                        end else begin
                            c_r <= c_r + 17'd1;
                            if (fall_s) begin
                                ival_mem_r[edge_idx_r] <= ival_next_s;
                                ival_r                 <= 17'd0;
                                edge_idx_r             <= edge_idx_r + 2'd1;
                                if (edge_idx_r == 2'd3) begin
                                    state_r <= ST_CHECK;
                                end
                            end else begin
                                ival_r <= ival_next_s;
                            end
                        end
                    end
                    ST_CHECK: begin
                        busy_r  <= 1'b0;
                        if (div_s < MIN_DIV) begin
                            err_r      <= 1'b1;
                            err_code_r <= 2'd1;
                            state_r    <= ST_IDLE;
                        end else if (mismatch_s) begin
                            err_r      <= 1'b1;
                            err_code_r <= 2'd3;
                            state_r    <= ST_IDLE;
                        end else begin
                            baud_div_r <= div_s;
                            soft_rst_r <= 1'b0;
                            done_r     <= 1'b1;
                            state_r    <= ST_APPLY;
                        end
                    end
                    ST_APPLY: begin
                        state_r <= ST_IDLE;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign baud_div = baud_div_r;
    assign soft_rst = soft_rst_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign err      = err_r;
    assign err_code = err_code_r;

endmodule

// File: tb/tb_pp_uart_autobaud.sv
// Testbench for pp_uart_autobaud: table of sync characters, corner sequences,
// and random interval sets scored against an arithmetic model of the divisor rules.
module tb_pp_uart_autobaud;

    localparam int TO_C = 6000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        rxd;
    logic [13:0] baud_div;
    logic        soft_rst;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int e5_cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int soft_cnt = 0;
    logic [13:0] cur_div;

    typedef struct {
        int          i0, i1, i2, i3;
        bit          ok;
        logic [1:0]  code;
        logic [13:0] dv;
    } vec_t;
    vec_t tbl [9];

    pp_uart_autobaud #(.TIMEOUT_C(17'd6000)) dut (
        .clk(clk), .rst(rst), .start(start), .rxd(rxd), .baud_div(baud_div),
        .soft_rst(soft_rst), .busy(busy), .done(done), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse counters sampled on the inactive edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) done_cnt <= done_cnt + 1;
            if (err) err_cnt <= err_cnt + 1;
            if (!soft_rst) soft_cnt <= soft_cnt + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    // Five falling edges separated by the given intervals; line left low after edge 5.
    task automatic send_ivs(input int iv[4]);
        rxd = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick(iv[k] / 2);
            rxd = 1'b1;
            tick(iv[k] - iv[k] / 2);
            rxd = 1'b0;
        end
        e5_cyc = cyc;
    endtask

    task automatic wait_result(input int bound, output bit found, output int lat);
        found = 1'b0;
        lat = -1;
        for (int i = 0; i < bound; i++) begin
            tick(1);
            if (i == 6) rxd = 1'b1;
            if (done || err) begin
                found = 1'b1;
                lat = cyc - e5_cyc;
                break;
            end
        end
        rxd = 1'b1;
    endtask

    // Reference: C is the sum of the four intervals; rounding, range and consistency rules.
    function automatic void model(input int iv[4], output bit ok, output logic [1:0] code,
                                  output logic [13:0] dv);
        int c, d, diff;
        bit bad;
        c = iv[0] + iv[1] + iv[2] + iv[3];
        d = (c + 4) / 8;
        dv = d[13:0];
        ok = 1'b0;
        code = 2'd0;
        bad = 1'b0;
        if (d < 16) begin
            code = 2'd1;
        end else begin
            for (int k = 1; k < 4; k++) begin
                diff = iv[k] - iv[0];
                if (diff < 0) diff = -diff;
                if (diff > iv[0] / 4) bad = 1'b1;
            end
            if (bad) code = 2'd3;
            else ok = 1'b1;
        end
    endfunction

    task automatic run_vec(input string nm, input int iv[4], input bit ok,
                           input logic [1:0] code, input logic [13:0] dv);
        int d0, e0, s0, lat;
        bit found;
        d0 = done_cnt; e0 = err_cnt; s0 = soft_cnt;
        rxd = 1'b1;
        do_start();
        check({nm, "_busy_on"}, busy, 1);
        tick(20);
        send_ivs(iv);
        wait_result(40, found, lat);
        check({nm, "_result_seen"}, found, 1);
        check({nm, "_latency"}, lat, 4);
        check({nm, "_busy_off"}, busy, 0);
        if (ok) begin
            check({nm, "_done"}, done, 1);
            check({nm, "_div"}, baud_div, dv);
            check({nm, "_soft_rst_low"}, soft_rst, 0);
            cur_div = dv;
        end else begin
            check({nm, "_err"}, err, 1);
            check({nm, "_err_code"}, err_code, code);
            check({nm, "_div_kept"}, baud_div, cur_div);
        end
        tick(1);
        check({nm, "_pulse_width"}, {soft_rst, done, err}, 3'b100);
        tick(5);
        check({nm, "_code_held"}, err_code, ok ? 2'd0 : code);
        check({nm, "_soft_cnt"}, soft_cnt - s0, ok ? 1 : 0);
        check({nm, "_done_cnt"}, done_cnt - d0, ok ? 1 : 0);
        check({nm, "_err_cnt"}, err_cnt - e0, ok ? 0 : 1);
    endtask

    initial begin
        int iv[4];
        int lat, base, j;
        bit found, ok;
        logic [1:0] code;
        logic [13:0] dv;
        int d0, e0;

        tbl[0] = '{200, 200, 200, 200, 1'b1, 2'd0, 14'd100};
        tbl[1] = '{435, 435, 435, 436, 1'b1, 2'd0, 14'd218};
        tbl[2] = '{434, 434, 434, 434, 1'b1, 2'd0, 14'd217};
        tbl[3] = '{20, 20, 20, 20, 1'b0, 2'd1, 14'd0};
        tbl[4] = '{200, 200, 300, 200, 1'b0, 2'd3, 14'd0};
        tbl[5] = '{200, 250, 150, 200, 1'b1, 2'd0, 14'd100};
        tbl[6] = '{32, 32, 32, 32, 1'b1, 2'd0, 14'd16};
        tbl[7] = '{30, 30, 30, 30, 1'b0, 2'd1, 14'd0};
        tbl[8] = '{200, 200, 200, 251, 1'b0, 2'd3, 14'd0};

        rst = 1'b1; start = 1'b0; rxd = 1'b1;
        cur_div = 14'd434;
        tick(3);
        check("reset_div", baud_div, 14'd434);
        check("reset_flags", {soft_rst, busy, done, err, err_code}, 6'b100000);
        rst = 1'b0;
        tick(2);
        check("post_reset_idle", {soft_rst, busy, done, err}, 4'b1000);

        for (int v = 0; v < 9; v++) begin
            iv = '{tbl[v].i0, tbl[v].i1, tbl[v].i2, tbl[v].i3};
            run_vec($sformatf("tbl%0d", v), iv, tbl[v].ok, tbl[v].code, tbl[v].dv);
        end

        // Asynchronous reset in the middle of a measurement.
        do_start();
        tick(20);
        rxd = 1'b0; tick(100); rxd = 1'b1; tick(100); rxd = 1'b0; tick(50);
        rst = 1'b1;
        #1;
        check("rst_mid_div", baud_div, 14'd434);
        check("rst_mid_flags", {soft_rst, busy, done, err, err_code}, 6'b100000);
        cur_div = 14'd434;
        tick(2);
        rst = 1'b0;
        rxd = 1'b1;
        tick(20);
        d0 = done_cnt; e0 = err_cnt;
        iv = '{200, 200, 200, 200};
        send_ivs(iv);
        wait_result(40, found, lat);
        check("no_start_ignored", found, 0);
        check("no_start_counts", (done_cnt - d0) + (err_cnt - e0), 0);
        check("no_start_state", {baud_div, busy}, {14'd434, 1'b0});

        // Restart while measuring: no pulse, busy stays up, then a clean run.
        do_start();
        tick(20);
        rxd = 1'b0; tick(100); rxd = 1'b1; tick(100); rxd = 1'b0; tick(50);
        rxd = 1'b1;
        d0 = done_cnt; e0 = err_cnt;
        do_start();
        check("abort_busy", busy, 1);
        tick(20);
        check("abort_busy_held", busy, 1);
        check("abort_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
        send_ivs(iv);
        wait_result(40, found, lat);
        check("abort_rerun_done", {found, done}, 2'b11);
        check("abort_rerun_div", baud_div, 14'd100);
        cur_div = 14'd100;
        tick(3);

        // One edge then a stuck-low line runs into the measurement timeout.
        rxd = 1'b1;
        do_start();
        tick(20);
        rxd = 1'b0;
        e5_cyc = cyc;
        found = 1'b0;
        lat = -1;
        for (int i = 0; i < TO_C + 50; i++) begin
            tick(1);
            if (done || err) begin
                found = 1'b1;
                lat = cyc - e5_cyc;
                break;
            end
        end
        check("timeout_seen", {found, err, done}, 3'b110);
        check("timeout_code", err_code, 2'd2);
        check("timeout_window", (lat >= TO_C) && (lat <= TO_C + 8), 1);
        check("timeout_div_kept", {baud_div, soft_rst, busy}, {cur_div, 1'b1, 1'b0});
        rxd = 1'b1;
        tick(5);

        for (int r = 0; r < 16; r++) begin
            base = int'($urandom_range(14, 300));
            j = (r % 2 == 1) ? base / 3 : base / 10;
            for (int k = 0; k < 4; k++) begin
                iv[k] = base + int'($urandom_range(0, 2 * j)) - j;
            end
            model(iv, ok, code, dv);
            run_vec($sformatf("rnd%0d", r), iv, ok, code, dv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pp_uart_autobaud.md
# pp_uart_autobaud

Auto-baud controller for the peripheral UART. On software request it measures a 0x55 sync character on the raw receive line and computes the 14-bit fractional divisor (10-bit integer, 4-bit sixteenths) for the UART baud-tick generator. It then loads that divisor and pulses the generator's active-low soft reset, so the new rate starts from a clean phase. The block sits between the UART register file and the baud generator and owns the divisor register.

## Interface
- DEFAULT_DIV, 14'd434: baud_div value after reset.
- MIN_DIV, 14'd16: smallest legal result (integer part ≥ 1).
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle request to run detection; restarts detection if busy.
- rxd  in  1  raw UART receive line, asynchronous; the block synchronises it internally.
- baud_div  out  14  divisor to the baud generator; [13:4] integer part, [3:0] sixteenths.
- soft_rst  out  1  active-low soft reset to the baud generator.
- busy  out  1  high from the cycle after start until done/err.
- done  out  1  one-cycle pulse: new divisor applied.
- err  out  1  one-cycle pulse: detection failed.
- err_code  out  2  valid with err and held until the next start: 1 too fast, 2 timeout, 3 interval mismatch.

## Operation
- rxd passes through a 2-flop synchroniser, then a history flop. Falling edge = previous 1, current 0.
- FSM states: IDLE, WAIT_IDLE, WAIT_EDGE, MEASURE, CHECK, APPLY.
- IDLE: waits for start, then goes to WAIT_IDLE.
- WAIT_IDLE: requires synchronised rxd = 1 for 16 consecutive cycles, then goes to WAIT_EDGE. Any 0 restarts the 16-cycle count. No timeout.
- WAIT_EDGE: the first falling edge (start bit) clears the 17-bit total counter C and the interval counter, then goes to MEASURE. No timeout.
- MEASURE:
  - C and the interval counter increment every cycle.
  - On each falling edge the current interval is stored as I0..I3 and the interval counter clears.
  - The 4th stored interval (5th edge) moves the FSM to CHECK. C is then the cycle count from edge 1 to edge 5, i.e. 8 bit times.
- Timeout: if C reaches 131068 in MEASURE, raise err with code 2 and return to IDLE.
- CHECK, evaluated in this order:
  - div = (C + 4) >> 3, 14 bits; cannot overflow because C ≤ 131067.
  - If div < MIN_DIV: err, code 1.
  - Else if any k in 1..3 has |Ik − I0| > (I0 >> 2): err, code 3.
  - Else go to APPLY.
- APPLY: load baud_div = div, drive soft_rst = 0 and done = 1 for exactly this one cycle, then return to IDLE.
- On any error, baud_div is unchanged and soft_rst stays 1.
- start in any non-IDLE state aborts the run without done or err, clears counters, and enters WAIT_IDLE. A start coinciding with APPLY is ignored: APPLY completes.
- rst at any time returns everything to reset values immediately.
- Reset values: baud_div = DEFAULT_DIV, soft_rst = 1, busy = 0, done = 0, err = 0, err_code = 0, FSM = IDLE.

## Timing
- All outputs are registered.
- rxd-to-edge-detect latency is 3 cycles. It is equal for all edges, so it does not affect C or Ik.
- Edge 5 detected in cycle t: CHECK in t+1, APPLY (or err) outputs visible in cycle t+2.
- done, err, and soft_rst low are each exactly one cycle wide. busy falls in the same cycle that done or err is high.
- Divisor arithmetic: the average tick period is baud_div/16 clocks, i.e. 1/16 of the bit time.

## Test plan
- Reset: assert rst mid-MEASURE -> baud_div = 434, soft_rst = 1, busy = 0, done/err = 0. A subsequent 0x55 is ignored without start.
- start, 16+ idle cycles, 0x55 at 100 clk/bit (C = 800) -> done 2 cycles after edge 5, baud_div = 100, soft_rst low for that one cycle.
- Intervals 435, 435, 435, 436 (C = 1741) -> baud_div = 218, done. Intervals 434 × 4 (C = 1736) -> baud_div = 217.
- 0x55 at 10 clk/bit (C = 80) -> err, err_code = 1, baud_div unchanged, soft_rst never low.
- Intervals 200, 200, 300, 200 -> err, err_code = 3. Intervals 200, 250, 150, 200 -> done, baud_div = 100.
- One falling edge, then rxd held low -> err, err_code = 2 when C reaches 131068. start mid-MEASURE -> no done/err, busy stays high, and a new 0x55 at 100 clk/bit -> baud_div = 100.
